// File: rtl/datacache_victim_wb_buffer.sv
// Single-entry dirty-victim writeback buffer: captures an evicted line, drains it
// as a burst of memory beats, and serves miss-path lookups while the line is held.
module datacache_victim_wb_buffer #(
   parameter  int unsigned S_OFFSET = 5,
   parameter  int unsigned S_INDEX  = 3,
   parameter  int unsigned S_BEAT   = 64,
   localparam int unsigned S_LINE   = 8 * (1 << S_OFFSET),
   localparam int unsigned S_TAG    = 32 - S_OFFSET - S_INDEX
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              evict_valid_i,
   input  logic              evict_dirty_i,
   input  logic [S_TAG-1:0]  evict_tag_i,
   input  logic [S_INDEX-1:0] evict_index_i,
   input  logic [S_LINE-1:0] evict_data_i,
   output logic              evict_ready_o,
   input  logic [31:0]       lookup_addr_i,
   output logic              lookup_hit_o,
   output logic [S_LINE-1:0] lookup_data_o,
   output logic              mem_write_o,
   output logic [31:0]       mem_address_o,
   output logic [S_BEAT-1:0] mem_wdata_o,
   input  logic              mem_resp_i,
   output logic              wb_busy_o
);

   localparam int unsigned BEATS   = S_LINE / S_BEAT;
   localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned BYTE_SH = $clog2(S_BEAT / 8);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   typedef enum logic [1:0] {ST_EMPTY, ST_HOLD, ST_BURST} state_e;

   state_e               state_q, state_d;
   logic [BEAT_W-1:0]    beat_q, beat_d;
   logic                 valid_q, valid_d;
   logic [S_TAG-1:0]     tag_q, tag_d;
   logic [S_INDEX-1:0]   index_q, index_d;
   logic [S_LINE-1:0]    data_q, data_d;
   logic                 unused_lookup_offset;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_EMPTY;
         beat_q  <= '0;
         valid_q <= 1'b0;
         tag_q   <= '0;
         index_q <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         valid_q <= valid_d;
         tag_q   <= tag_d;
         index_q <= index_d;
         data_q  <= data_d;
      end
   end

   // Next state; handshake outputs depend on registered state only.
   always_comb begin
      state_d       = state_q;
      beat_d        = beat_q;
      valid_d       = valid_q;
      tag_d         = tag_q;
      index_d       = index_q;
      data_d        = data_q;
      evict_ready_o = 1'b0;
      wb_busy_o     = 1'b1;
      mem_write_o   = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            evict_ready_o = 1'b1;
            wb_busy_o     = 1'b0;
            if (evict_valid_i && evict_dirty_i) begin
               tag_d   = evict_tag_i;
               index_d = evict_index_i;
               data_d  = evict_data_i;
               valid_d = 1'b1;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            beat_d  = '0;
            state_d = ST_BURST;
         end
         ST_BURST: begin
            mem_write_o = 1'b1;
            if (mem_resp_i) begin
               if (beat_q == LAST_BEAT) begin
                  valid_d = 1'b0;
                  state_d = ST_EMPTY;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // Beat payload is driven only while a write is requested, zero otherwise.
   assign mem_address_o = mem_write_o
                          ? ({tag_q, index_q, S_OFFSET'(0)} | (32'(beat_q) << BYTE_SH))
                          : '0;
   assign mem_wdata_o   = mem_write_o ? data_q[32'(beat_q) * S_BEAT +: S_BEAT] : '0;

   assign lookup_hit_o  = valid_q && (lookup_addr_i[31:S_OFFSET] == {tag_q, index_q});
   assign lookup_data_o = valid_q ? data_q : '0;

   assign unused_lookup_offset = ^lookup_addr_i[S_OFFSET-1:0];

endmodule

// File: tb/tb_datacache_victim_wb_buffer.sv
// Bench for datacache_victim_wb_buffer: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the held line and its beats.
module tb_datacache_victim_wb_buffer;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         evict_valid = 1'b0;
   logic         evict_dirty = 1'b0;
   logic [23:0]  evict_tag = '0;
   logic [2:0]   evict_index = '0;
   logic [255:0] evict_data = '0;
   logic         evict_ready;
   logic [31:0]  lookup_addr = '0;
   logic         lookup_hit;
   logic [255:0] lookup_data;
   logic         mem_write;
   logic [31:0]  mem_address;
   logic [63:0]  mem_wdata;
   logic         mem_resp = 1'b0;
   logic         wb_busy;

   datacache_victim_wb_buffer dut (
      .clk_i(clk), .rst_i(rst),
      .evict_valid_i(evict_valid), .evict_dirty_i(evict_dirty),
      .evict_tag_i(evict_tag), .evict_index_i(evict_index), .evict_data_i(evict_data),
      .evict_ready_o(evict_ready),
      .lookup_addr_i(lookup_addr), .lookup_hit_o(lookup_hit), .lookup_data_o(lookup_data),
      .mem_write_o(mem_write), .mem_address_o(mem_address), .mem_wdata_o(mem_wdata),
      .mem_resp_i(mem_resp), .wb_busy_o(wb_busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: a held line plus the queue of beats still owed to memory.
   bit           m_valid = 1'b0;
   bit           m_setup = 1'b0;
   logic [23:0]  m_tag = '0;
   logic [2:0]   m_index = '0;
   logic [255:0] m_data = '0;
   logic [31:0]  q_addr[$];
   logic [63:0]  q_data[$];
   logic [31:0]  obs_addr[$];
   logic [63:0]  obs_data[$];
   int           resp_mode = 0;
   int           cyc = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] rand_line();
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   task automatic cycle(output bit accepted);
      bit exp_write, exp_hit;
      @(negedge clk);
      exp_write = m_valid && !m_setup;
      exp_hit   = m_valid && (lookup_addr[31:5] == {m_tag, m_index});
      chk("evict_ready", 256'(evict_ready), 256'(!m_valid));
      chk("wb_busy", 256'(wb_busy), 256'(m_valid));
      chk("mem_write", 256'(mem_write), 256'(exp_write));
      if (exp_write) begin
         chk("mem_address", 256'(mem_address), 256'(q_addr[0]));
         chk("mem_wdata", 256'(mem_wdata), 256'(q_data[0]));
      end
      chk("lookup_hit", 256'(lookup_hit), 256'(exp_hit));
      if (exp_hit) chk("lookup_data", lookup_data, m_data);
      if (mem_write && mem_resp) begin
         obs_addr.push_back(mem_address);
         obs_data.push_back(mem_wdata);
      end
      @(posedge clk);
      accepted = 1'b0;
      if (rst) begin
         m_valid = 1'b0;
         m_setup = 1'b0;
         q_addr.delete();
         q_data.delete();
      end else if (!m_valid) begin
         if (evict_valid) begin
            accepted = 1'b1;
            if (evict_dirty) begin
               m_valid = 1'b1;
               m_setup = 1'b1;
               m_tag   = evict_tag;
               m_index = evict_index;
               m_data  = evict_data;
               for (int b = 0; b < 4; b++) begin
                  q_addr.push_back({evict_tag, evict_index, 5'b0} + 32'(b * 8));
                  q_data.push_back(evict_data[b*64 +: 64]);
               end
            end
         end
      end else if (m_setup) begin
         m_setup = 1'b0;
      end else if (mem_resp) begin
         void'(q_addr.pop_front());
         void'(q_data.pop_front());
         if (q_addr.size() == 0) m_valid = 1'b0;
      end
      #1;
      cyc++;
      case (resp_mode)
         0: mem_resp = 1'b0;
         1: mem_resp = cyc[0];
         2: mem_resp = 1'($urandom % 2);
         default: ;
      endcase
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) cycle(a);
   endtask

   task automatic evict(input logic [23:0] t, input logic [2:0] ix,
                        input logic [255:0] d, input bit dirty);
      bit a = 1'b0;
      evict_valid = 1'b1;
      evict_dirty = dirty;
      evict_tag   = t;
      evict_index = ix;
      evict_data  = d;
      for (int i = 0; i < 100 && !a; i++) cycle(a);
      evict_valid = 1'b0;
      chk("evict_accepted", 256'(a), 256'(1));
   endtask

   task automatic drain();
      bit a;
      for (int i = 0; i < 64 && m_valid; i++) cycle(a);
      chk("drain_done", 256'(m_valid), 256'(0));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] line;
      bit a;
      bit hold_req;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      idle(10);

      // Directed dirty eviction with lookups of the held line and its neighbour.
      line = {64'h4444444444444444, 64'h3333333333333333,
              64'h2222222222222222, 64'h1111111111111111};
      resp_mode = 1;
      lookup_addr = 32'hABCDE17C;
      obs_addr.delete();
      obs_data.delete();
      evict(24'hABCDE1, 3'd3, line, 1'b1);
      idle(1);
      lookup_addr = 32'hABCDE180;
      idle(2);
      lookup_addr = 32'hABCDE17C;
      drain();
      idle(1);
      chk("beats_seen", 256'(obs_addr.size()), 256'(4));
      if (obs_addr.size() == 4) begin
         chk("beat0_addr", 256'(obs_addr[0]), 256'(32'hABCDE160));
         chk("beat1_addr", 256'(obs_addr[1]), 256'(32'hABCDE168));
         chk("beat2_addr", 256'(obs_addr[2]), 256'(32'hABCDE170));
         chk("beat3_addr", 256'(obs_addr[3]), 256'(32'hABCDE178));
         chk("beat0_data", 256'(obs_data[0]), 256'(64'h1111111111111111));
         chk("beat3_data", 256'(obs_data[3]), 256'(64'h4444444444444444));
      end

      // Clean eviction completes the handshake but writes nothing.
      resp_mode = 0;
      evict(24'h123456, 3'd5, rand_line(), 1'b0);
      idle(8);

      // Second eviction waits through the first burst.
      resp_mode = 1;
      evict(24'h0F0F0F, 3'd1, rand_line(), 1'b1);
      evict(24'h0F0F0F, 3'd2, rand_line(), 1'b1);
      chk("second_held", 256'(m_valid), 256'(1));
      drain();

      // Reset after two beats abandons the burst.
      resp_mode = 3;
      mem_resp = 1'b0;
      evict(24'hBEEF01, 3'd7, rand_line(), 1'b1);
      idle(1);
      mem_resp = 1'b1;
      idle(2);
      mem_resp = 1'b0;
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      idle(6);

      // Random traffic with upstream holding unaccepted requests.
      resp_mode = 2;
      hold_req = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (!hold_req) begin
            evict_valid = ($urandom % 3) == 0;
            evict_dirty = ($urandom % 4) != 0;
            evict_tag   = 24'($urandom);
            evict_index = 3'($urandom);
            evict_data  = rand_line();
         end
         if ($urandom % 2) lookup_addr = {m_tag, m_index, 5'($urandom)};
         else              lookup_addr = $urandom;
         rst = ($urandom % 200) == 0;
         cycle(a);
         hold_req = evict_valid && !a;
      end
      rst = 1'b0;
      evict_valid = 1'b0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
